// File: rtl/abc_serial_loader.sv
// abc_serial_loader
//   Serial front end for the 3-bit ABC code decoder. A frame on SIN is one
//   start bit (0), DATA_W data bits sent MSB first, and one stop bit (1).
//   Each bit is sampled in the middle of its bit period. ABC is loaded from
//   the shadow register only when the stop bit is good, so the decoder never
//   sees a partial code.
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   SIN        serial input; idles high
//   ABC        last valid code, held between frames
//   abc_valid  one-cycle strobe after ABC is loaded
//   frame_err  one-cycle strobe after a stop bit is sampled low
//   busy       high whenever the receiver is not idle
module abc_serial_loader #(
   parameter int                DATA_W     = 3,
   parameter int                BIT_CYCLES = 4,
   parameter logic [DATA_W-1:0] RESET_CODE = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SIN,
   output logic [DATA_W-1:0] ABC,
   output logic              abc_valid,
   output logic              frame_err,
   output logic              busy
);

   localparam int H  = BIT_CYCLES / 2;
   localparam int CW = $clog2(BIT_CYCLES) + 1;
   localparam int BW = $clog2(DATA_W) + 1;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     cyc;
   logic [BW-1:0]     bitn;
   logic [DATA_W-1:0] shadow;
   logic              shift, load, err;

   // Counter value seen at an edge is (edges since the last clear) - 1, so a
   // sample point k edges after the clear is reached when cyc == k-1.
   always_comb begin
      state_nx = state;
      shift    = 1'b0;
      load     = 1'b0;
      err      = 1'b0;
      case (state)
         IDLE:    if (!SIN) state_nx = START;
         START:   if (cyc == CW'(H - 1)) state_nx = SIN ? IDLE : DATA;
         DATA:    if (cyc == CW'(BIT_CYCLES - 1)) begin
                     shift = 1'b1;
                     if (bitn == BW'(DATA_W - 1)) state_nx = STOP;
                  end
         STOP:    if (cyc == CW'(BIT_CYCLES - 1)) begin
                     if (SIN) begin
                        load     = 1'b1;
                        state_nx = IDLE;
                     end else begin
                        err      = 1'b1;
                        state_nx = WAIT_HI;
                     end
                  end
         // A low stop bit must go high again before a new start is accepted.
         WAIT_HI: if (SIN) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cyc       <= '0;
         bitn      <= '0;
         shadow    <= '0;
         ABC       <= RESET_CODE;
         abc_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nx;
         abc_valid <= load;
         frame_err <= err;
         // Cleared on every state entry and after each data bit; only counts
         // in the timed states so it never wraps while waiting.
         if (state_nx != state || shift)
            cyc <= '0;
         else if (state == START || state == DATA || state == STOP)
            cyc <= cyc + CW'(1);
         if (state_nx != state)
            bitn <= '0;
         else if (shift)
            bitn <= bitn + BW'(1);
         if (shift)
            shadow <= {shadow[DATA_W-2:0], SIN};
         if (load)
            ABC <= shadow;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_abc_serial_loader.sv
// tb_abc_serial_loader
//   Bench for abc_serial_loader (defaults DATA_W=3, BIT_CYCLES=4). A frame-level
//   reference model, driven off the edge count since the start edge, predicts
//   ABC / strobes / busy every cycle; table vectors and hand sequences add
//   end-of-frame checks.
module tb_abc_serial_loader;

   localparam int DW = 3;
   localparam int B  = 4;
   localparam int H  = B / 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sin = 1'b1;
   logic [DW-1:0] abc;
   logic          v, fe, busy;

   always #5 clk = ~clk;

   abc_serial_loader dut (
      .clk       (clk),
      .rst       (rst),
      .SIN       (sin),
      .ABC       (abc),
      .abc_valid (v),
      .frame_err (fe),
      .busy      (busy)
   );

   int tests = 0;
   int fails = 0;
   int cyc_n = 0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   // Reference model: mode 0 idle, 1 in frame, 2 waiting for SIN high.
   int            m_mode = 0;
   int            m_e0   = 0;
   logic [DW-1:0] m_abc  = '0;
   logic [DW-1:0] m_sh   = '0;
   logic          m_v    = 1'b0;
   logic          m_e    = 1'b0;
   int            d, k;

   int            vcnt = 0, ecnt = 0, bcnt = 0;
   int            vtimes[$];
   logic [DW-1:0] vabc[$];

   always @(posedge clk) begin
      cyc_n++;
      if (rst) begin
         m_mode = 0; m_abc = '0; m_v = 1'b0; m_e = 1'b0;
      end else begin
         m_v = 1'b0; m_e = 1'b0;
         case (m_mode)
            0: if (!sin) begin m_mode = 1; m_e0 = cyc_n; end
            1: begin
               d = cyc_n - m_e0;
               if (d == H) begin
                  if (sin) m_mode = 0;
               end else if (d > H && (d - H) % B == 0) begin
                  k = (d - H) / B;
                  if (k <= DW) m_sh = {m_sh[DW-2:0], sin};
                  else if (sin) begin m_abc = m_sh; m_v = 1'b1; m_mode = 0; end
                  else begin m_e = 1'b1; m_mode = 2; end
               end
            end
            default: if (sin) m_mode = 0;
         endcase
      end
      #1;
      chk("abc", abc, m_abc);
      chk("abc_valid", v, m_v);
      chk("frame_err", fe, m_e);
      chk("busy", busy, (m_mode != 0) ? 1 : 0);
      if (v) begin vcnt++; vtimes.push_back(cyc_n); vabc.push_back(abc); end
      if (fe) ecnt++;
      if (busy) bcnt++;
   end

   task automatic idle(input int n);
      sin = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [DW-1:0] dat, input logic stop, input int stop_len);
      sin = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = DW - 1; i >= 0; i--) begin
         sin = dat[i];
         repeat (B) @(negedge clk);
      end
      sin = stop;
      repeat (stop ? B : stop_len) @(negedge clk);
      sin = 1'b1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 100) begin @(negedge clk); n++; end
      chk("idle_timeout", busy, 0);
   endtask

   typedef struct {
      logic [DW-1:0] data;
      logic          stop;
      int            stop_len;
      logic [DW-1:0] exp_abc;
      int            exp_v;
      int            exp_e;
   } vec_t;

   vec_t tbl[5];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{3'b101, 1'b1, 4, 3'b101, 1, 0};
      tbl[1] = '{3'b111, 1'b0, 8, 3'b101, 0, 1};
      tbl[2] = '{3'b010, 1'b1, 4, 3'b010, 1, 0};
      tbl[3] = '{3'b110, 1'b1, 4, 3'b110, 1, 0};
      tbl[4] = '{3'b011, 1'b0, 5, 3'b110, 0, 1};

      // T1 reset
      rst = 1'b1; sin = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_abc", abc, 0);
      chk("rst_valid", v, 0);
      chk("rst_err", fe, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      idle(3);

      // T2 / T4 and more frames from the table
      foreach (tbl[i]) begin
         vcnt = 0; ecnt = 0;
         send_frame(tbl[i].data, tbl[i].stop, tbl[i].stop_len);
         idle(1);
         wait_idle();
         idle(2);
         chk($sformatf("vec%0d_abc", i), abc, tbl[i].exp_abc);
         chk($sformatf("vec%0d_valid_pulses", i), vcnt, tbl[i].exp_v);
         chk($sformatf("vec%0d_err_pulses", i), ecnt, tbl[i].exp_e);
      end

      // T3 one-cycle glitch
      vcnt = 0; ecnt = 0; bcnt = 0;
      sin = 1'b0;
      @(negedge clk);
      idle(6);
      chk("glitch_busy_cycles", bcnt, H);
      chk("glitch_valid", vcnt, 0);
      chk("glitch_err", ecnt, 0);
      chk("glitch_abc", abc, 3'b110);

      // T5 reset at edge e0+10 of a 111 frame
      vcnt = 0; ecnt = 0;
      for (int c = 0; c <= 10; c++) begin
         sin = (c < B) ? 1'b0 : 1'b1;
         rst = (c == 10);
         @(negedge clk);
      end
      rst = 1'b0;
      idle(3);
      chk("midrst_abc", abc, 0);
      chk("midrst_valid", vcnt, 0);
      chk("midrst_err", ecnt, 0);
      chk("midrst_busy", busy, 0);
      send_frame(3'b111, 1'b1, 4);
      idle(2);
      chk("after_rst_abc", abc, 3'b111);
      chk("after_rst_valid", vcnt, 1);

      // T6 back-to-back frames
      vcnt = 0;
      vtimes.delete(); vabc.delete();
      send_frame(3'b000, 1'b1, 4);
      send_frame(3'b110, 1'b1, 4);
      idle(4);
      chk("b2b_pulses", vcnt, 2);
      if (vtimes.size() == 2) begin
         chk("b2b_spacing", vtimes[1] - vtimes[0], (DW + 2) * B);
         chk("b2b_abc0", vabc[0], 3'b000);
         chk("b2b_abc1", vabc[1], 3'b110);
      end

      // Randomized traffic, checked cycle by cycle against the model
      for (int it = 0; it < 150; it++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 4) send_frame(3'($urandom_range(0, 7)), 1'b1, 4);
         else if (r == 5) send_frame(3'($urandom_range(0, 7)), 1'b0, $urandom_range(1, 10));
         else if (r == 6) begin sin = 1'b0; @(negedge clk); sin = 1'b1; end
         else if (r == 7) begin
            for (int j = 0; j < 10; j++) begin sin = 1'($urandom_range(0, 1)); @(negedge clk); end
         end else if (r == 8) begin
            sin = 1'b0;
            repeat ($urandom_range(1, 18)) @(negedge clk);
            rst = 1'b1; @(negedge clk); rst = 1'b0;
         end
         idle($urandom_range(0, 3));
      end
      idle(30);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
